umi_req_fifo: RTL



---
 rtl/umi_req_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/umi_req_fifo.sv
// umi_req_fifo: elastic request buffer in front of the UMI endpoint input port.
// A DEPTH-entry circular FIFO with a separate occupancy count. Full, empty and
// almost-full are held in registers next to the count.
// Optional macro UMI_REQ_FIFO_BYPASS_EN adds a zero-latency path: when the FIFO
// is empty and the endpoint is ready, an incoming packet goes straight through.
module umi_req_fifo #(
  parameter int UW    = 256,
  parameter int DEPTH = 4,
  parameter int AFULL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     umi_in_valid,
  input  logic [UW-1:0]            umi_in_packet,
  output logic                     umi_in_ready,
  output logic                     umi_out_valid,
  output logic [UW-1:0]            umi_out_packet,
  input  logic                     umi_out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     fifo_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [UW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          afull_r;
  logic          clear_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;

  // Reset and flush act identically and win over every other event.
  assign clear_s = reset | flush;

  // Handshake and head-packet decode; the bypass build forwards the input
  // packet whenever the FIFO holds nothing.
  always_comb begin
    umi_in_ready = !full_r & !clear_s;
`ifdef UMI_REQ_FIFO_BYPASS_EN
    bypass_s      = empty_r & umi_in_valid & umi_out_ready & !clear_s;
    umi_out_valid = (umi_in_valid | !empty_r) & !clear_s;
    if (empty_r) begin
      umi_out_packet = umi_in_packet;
    end else begin
      umi_out_packet = mem[rd_ptr_r];
    end
`else
    bypass_s       = 1'b0;
    umi_out_valid  = !empty_r & !clear_s;
    umi_out_packet = mem[rd_ptr_r];
`endif
    // A bypassed packet is consumed directly and never written.
    push_s = umi_in_valid & umi_in_ready & !bypass_s;
    // Only stored entries can be popped.
    pop_s  = umi_out_valid & umi_out_ready & !empty_r;
  end

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and registered status flags; clear returns all to empty.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == '0);
      full_r  <= (count_nxt_s == CW'(DEPTH));
      afull_r <= (count_nxt_s >= CW'(AFULL));
    end
  end

  // Packet storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= umi_in_packet;
    end
  end

  assign fifo_count = count_r;
  assign fifo_empty = empty_r;
  assign fifo_full  = full_r;
  assign fifo_afull = afull_r;

endmodule
